// File: rtl/branch_resolve.sv
// Execute-side branch resolution: pops fetch predictions in order, evaluates the real
// condition, and on a wrong guess redirects fetch, flushes the front end and retrains the predictor.
module branch_resolve #(
  parameter int DEPTH     = 4,
  parameter int PC_W      = 10,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_target,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic [2:0]               res_funct3,
  input  logic [31:0]              res_rs1,
  input  logic [31:0]              res_rs2,
  output logic                     mispredict,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     flush,
  output logic                     bp_upd_valid,
  output logic [7:0]               bp_upd_idx,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         resolved_cnt,
  output logic [CNT_W-1:0]         mispred_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FC_W  = $clog2(FLUSH_CYC) + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state;
  logic [PC_W-1:0]   q_pc     [DEPTH];
  logic              q_taken  [DEPTH];
  logic [PC_W-1:0]   q_target [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [FC_W-1:0]   flush_cnt;

  logic              push;
  logic              pop;
  logic              legal;
  logic              actual;
  logic              mis;
  logic [PC_W-1:0]   head_pc;
  logic [PC_W-1:0]   head_target;
  logic              head_taken;

  assign pred_ready  = (state == RUN) && (count != (PTR_W+1)'(DEPTH));
  assign push        = pred_valid && pred_ready;
  assign pop         = res_valid && (count != '0);
  assign head_pc     = q_pc[head];
  assign head_target = q_target[head];
  assign head_taken  = q_taken[head];
  assign mis         = pop && (actual != head_taken);

  // funct3 010/011 have no branch meaning: treated as not-taken and reported via err
  always_comb begin
    legal  = 1'b1;
    actual = 1'b0;
    case (res_funct3)
      3'b000:  actual = (res_rs1 == res_rs2);
      3'b001:  actual = (res_rs1 != res_rs2);
      3'b100:  actual = ($signed(res_rs1) <  $signed(res_rs2));
      3'b101:  actual = ($signed(res_rs1) >= $signed(res_rs2));
      3'b110:  actual = (res_rs1 <  res_rs2);
      3'b111:  actual = (res_rs1 >= res_rs2);
      default: legal  = 1'b0;
    endcase
  end

  // Entry storage needs no reset; only slots between head and tail are ever read
  always_ff @(posedge clk) begin
    if (push && !mis) begin
      q_pc[tail]     <= pred_pc;
      q_taken[tail]  <= pred_taken;
      q_target[tail] <= pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      flush_cnt    <= '0;
      flush        <= 1'b0;
      mispredict   <= 1'b0;
      redirect_pc  <= '0;
      bp_upd_valid <= 1'b0;
      bp_upd_idx   <= '0;
      err          <= 1'b0;
      resolved_cnt <= '0;
      mispred_cnt  <= '0;
    end else begin
      mispredict   <= mis;
      bp_upd_valid <= mis;
      err          <= res_valid && ((count == '0) || !legal);

      if (pop && (resolved_cnt != '1))
        resolved_cnt <= resolved_cnt + CNT_W'(1);
      if (mis && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + CNT_W'(1);

      if (mis) begin
        redirect_pc <= actual ? head_target : head_pc + PC_W'(4);
        bp_upd_idx  <= head_pc[7:0];
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        state       <= FLUSH;
        flush       <= 1'b1;
        flush_cnt   <= FC_W'(FLUSH_CYC - 1);
      end else begin
        head  <= head + PTR_W'(pop);
        tail  <= tail + PTR_W'(push);
        count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        case (state)
          RUN: ;
          FLUSH: begin
            if (flush_cnt == '0) begin
              state <= RUN;
              flush <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt - FC_W'(1);
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios with literal expectations plus a random
// phase, all cross-checked every cycle against a queue-based behavioural model.
module tb_branch_resolve;

  localparam int DEPTH     = 4;
  localparam int PC_W      = 10;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   rst;
  logic                   pred_valid;
  logic [PC_W-1:0]        pred_pc;
  logic                   pred_taken;
  logic [PC_W-1:0]        pred_target;
  logic                   pred_ready;
  logic                   res_valid;
  logic [2:0]             res_funct3;
  logic [31:0]            res_rs1;
  logic [31:0]            res_rs2;
  logic                   mispredict;
  logic [PC_W-1:0]        redirect_pc;
  logic                   flush;
  logic                   bp_upd_valid;
  logic [7:0]             bp_upd_idx;
  logic                   err;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0]       resolved_cnt;
  logic [CNT_W-1:0]       mispred_cnt;

  branch_resolve #(
    .DEPTH(DEPTH), .PC_W(PC_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_funct3(res_funct3), .res_rs1(res_rs1), .res_rs2(res_rs2),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .flush(flush),
    .bp_upd_valid(bp_upd_valid), .bp_upd_idx(bp_upd_idx), .err(err),
    .count(count), .resolved_cnt(resolved_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } ent_t;

  ent_t            mq[$];
  int              m_flush_rem = 0;
  int              m_resolved  = 0;
  int              m_mispred   = 0;
  bit              exp_mis     = 0;
  bit              exp_err     = 0;
  logic [PC_W-1:0] exp_redirect = '0;
  logic [7:0]      exp_idx      = '0;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances one clock using the inputs the DUT just sampled
  task automatic modelStep();
    ent_t h;
    bit   act, legal, ready, push;
    if (rst) begin
      mq.delete();
      m_flush_rem = 0; m_resolved = 0; m_mispred = 0;
      exp_mis = 0; exp_err = 0; exp_redirect = '0; exp_idx = '0;
      return;
    end
    ready   = (m_flush_rem == 0) && (mq.size() < DEPTH);
    push    = pred_valid && ready;
    exp_mis = 0;
    exp_err = 0;
    if (m_flush_rem > 0) m_flush_rem--;
    if (res_valid) begin
      if (mq.size() == 0) begin
        exp_err = 1;
      end else begin
        h = mq.pop_front();
        if (m_resolved < CNT_MAX) m_resolved++;
        legal = 1;
        act   = 0;
        case (res_funct3)
          3'd0: act = (res_rs1 == res_rs2);
          3'd1: act = (res_rs1 != res_rs2);
          3'd4: act = ($signed(res_rs1) < $signed(res_rs2));
          3'd5: act = ($signed(res_rs1) >= $signed(res_rs2));
          3'd6: act = (res_rs1 < res_rs2);
          3'd7: act = (res_rs1 >= res_rs2);
          default: legal = 0;
        endcase
        if (!legal) exp_err = 1;
        if (act != h.taken) begin
          exp_mis      = 1;
          exp_idx      = h.pc[7:0];
          exp_redirect = act ? h.target : PC_W'(int'(h.pc) + 4);
          if (m_mispred < CNT_MAX) m_mispred++;
          mq.delete();
          m_flush_rem = FLUSH_CYC;
          push = 0;
        end
      end
    end
    if (push) mq.push_back('{pred_pc, pred_taken, pred_target});
  endtask

  task automatic applyStimulus(input bit pv, input logic [PC_W-1:0] pc, input bit tk,
                               input logic [PC_W-1:0] tgt, input bit rv, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b);
    pred_valid = pv; pred_pc = pc; pred_taken = tk; pred_target = tgt;
    res_valid = rv; res_funct3 = f3; res_rs1 = a; res_rs2 = b;
    @(posedge clk);
    #1;
    modelStep();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, 0, 3'd0, 0, 0);
  endtask

  task automatic push1(input logic [PC_W-1:0] pc, input bit tk, input logic [PC_W-1:0] tgt);
    applyStimulus(1, pc, tk, tgt, 0, 3'd0, 0, 0);
  endtask

  task automatic resolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(0, '0, 0, '0, 1, f3, a, b);
  endtask

  function automatic logic [31:0] pickOp();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("count", 32'(count), 32'(mq.size()));
      checkOutput("pred_ready", 32'(pred_ready), 32'((m_flush_rem == 0) && (mq.size() < DEPTH)));
      checkOutput("mispredict", 32'(mispredict), 32'(exp_mis));
      checkOutput("bp_upd_valid", 32'(bp_upd_valid), 32'(exp_mis));
      checkOutput("bp_upd_idx", 32'(bp_upd_idx), 32'(exp_idx));
      checkOutput("redirect_pc", 32'(redirect_pc), 32'(exp_redirect));
      checkOutput("flush", 32'(flush), 32'(m_flush_rem > 0));
      checkOutput("err", 32'(err), 32'(exp_err));
      checkOutput("resolved_cnt", 32'(resolved_cnt), 32'(m_resolved));
      checkOutput("mispred_cnt", 32'(mispred_cnt), 32'(m_mispred));
    end
  end

  initial begin
    rst = 1'b1;
    idle(2);
    check_en = 1;
    rst = 1'b0;
    checkOutput("rst count", 32'(count), 0);
    checkOutput("rst ready", 32'(pred_ready), 1);
    checkOutput("rst flush", 32'(flush), 0);
    checkOutput("rst redirect", 32'(redirect_pc), 0);
    checkOutput("rst resolved", 32'(resolved_cnt), 0);

    // Fill the queue, bounce a fifth push, then drain
    for (int i = 0; i < 4; i++) push1(PC_W'(32'h100 + 4 * i), 0, 10'h180);
    push1(10'h200, 0, 10'h180);
    checkOutput("full count", 32'(count), 4);
    checkOutput("full ready", 32'(pred_ready), 0);
    resolve(3'b000, 1, 2);
    checkOutput("pop count", 32'(count), 3);
    checkOutput("pop ready", 32'(pred_ready), 1);
    for (int i = 0; i < 3; i++) resolve(3'b000, 1, 2);
    checkOutput("drain resolved", 32'(resolved_cnt), 4);

    push1(10'h010, 1, 10'h030);
    resolve(3'b000, 5, 5);
    checkOutput("beq ok mispredict", 32'(mispredict), 0);
    checkOutput("beq ok count", 32'(count), 0);
    checkOutput("beq ok resolved", 32'(resolved_cnt), 5);

    // Not-taken fallthrough wraps the PC
    push1(10'h3FC, 1, 10'h020);
    resolve(3'b001, 7, 7);
    checkOutput("wrap mispredict", 32'(mispredict), 1);
    checkOutput("wrap redirect", 32'(redirect_pc), 32'h000);
    checkOutput("wrap idx", 32'(bp_upd_idx), 32'hFC);
    checkOutput("wrap flush1", 32'(flush), 1);
    checkOutput("wrap ready1", 32'(pred_ready), 0);
    checkOutput("wrap mispred_cnt", 32'(mispred_cnt), 1);
    idle(1);
    checkOutput("wrap flush2", 32'(flush), 1);
    checkOutput("wrap ready2", 32'(pred_ready), 0);
    idle(1);
    checkOutput("wrap flush3", 32'(flush), 0);
    checkOutput("wrap ready3", 32'(pred_ready), 1);

    push1(10'h040, 0, 10'h080);
    push1(10'h044, 0, 10'h090);
    push1(10'h048, 0, 10'h0A0);
    checkOutput("three count", 32'(count), 3);
    resolve(3'b100, 32'hFFFF_FFFF, 1);
    checkOutput("blt mispredict", 32'(mispredict), 1);
    checkOutput("blt redirect", 32'(redirect_pc), 32'h080);
    checkOutput("blt count", 32'(count), 0);
    checkOutput("blt mispred_cnt", 32'(mispred_cnt), 2);
    idle(2);
    push1(10'h050, 0, 10'h060);
    resolve(3'b110, 32'hFFFF_FFFF, 1);
    checkOutput("bltu mispredict", 32'(mispredict), 0);
    checkOutput("bltu flush", 32'(flush), 0);
    checkOutput("bltu resolved", 32'(resolved_cnt), 8);

    resolve(3'b000, 0, 0);
    checkOutput("empty err", 32'(err), 1);
    checkOutput("empty resolved", 32'(resolved_cnt), 8);
    idle(1);
    checkOutput("err clears", 32'(err), 0);
    push1(10'h070, 0, 10'h000);
    resolve(3'b010, 3, 3);
    checkOutput("illegal err", 32'(err), 1);
    checkOutput("illegal mispredict", 32'(mispredict), 0);
    checkOutput("illegal count", 32'(count), 0);
    checkOutput("illegal resolved", 32'(resolved_cnt), 9);

    // Reset lands in the second flush cycle
    push1(10'h3FC, 1, 10'h020);
    resolve(3'b001, 7, 7);
    idle(1);
    checkOutput("pre-rst flush", 32'(flush), 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("rst-flush flush", 32'(flush), 0);
    checkOutput("rst-flush ready", 32'(pred_ready), 1);
    checkOutput("rst-flush resolved", 32'(resolved_cnt), 0);
    checkOutput("rst-flush mispred", 32'(mispred_cnt), 0);

    for (int i = 0; i < 3000; i++) begin
      logic [PC_W-1:0] pc;
      pc  = PC_W'($urandom());
      rst = ($urandom_range(0, 399) == 0);
      applyStimulus($urandom_range(0, 9) < 6, pc, 1'($urandom()),
                    pc + PC_W'($urandom_range(0, 63) * 4),
                    $urandom_range(0, 9) < 4, 3'($urandom()), pickOp(), pickOp());
    end
    rst = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
